// File: rtl/treasure_tracker_pkg.sv
// Shared grid geometry and FSM state type for the treasure tracker.
package treasure_tracker_pkg;

   localparam int MAP_W    = 12;
   localparam int MAP_H    = 12;
   localparam int MAP_BITS = MAP_W * MAP_H;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      READY
   } state_t;

endpackage

// File: rtl/treasure_tracker_tile_index.sv
// Converts a tile coordinate into its bit position in the packed map (row 0 in the MSBs).
module tile_index
   import treasure_tracker_pkg::*;
(
   input  logic [3:0] X,
   input  logic [3:0] Y,
   output logic [7:0] idx,
   output logic       valid
);

   localparam logic [7:0] LAST_IDX = 8'(MAP_BITS - 1);

   logic [7:0] w_linear;

   // Invalid coordinates still produce an index; callers must gate with valid.
   always_comb begin
      w_linear = ({4'd0, Y} * 8'(MAP_W)) + {4'd0, X};
      idx      = LAST_IDX - w_linear;
      valid    = (X < 4'(MAP_W)) && (Y < 4'(MAP_H));
   end

endmodule

// File: rtl/treasure_tracker.sv
// Tracks live treasures for one level: counts the loaded map, then removes claimed tiles.
module treasure_tracker
   import treasure_tracker_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Load,
   input  logic [MAP_BITS-1:0] Map_In,
   input  logic                Collect_Valid,
   input  logic [3:0]          Collect_X,
   input  logic [3:0]          Collect_Y,
   input  logic [3:0]          Query_X,
   input  logic [3:0]          Query_Y,
   output logic                Query_Hit,
   output logic [MAP_BITS-1:0] Treasure_Live,
   output logic [7:0]          Remaining,
   output logic                Busy,
   output logic                Collect_Ack,
   output logic                Level_Clear
);

   localparam logic [7:0] LAST_IDX = 8'(MAP_BITS - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [MAP_BITS-1:0] r_live;
   logic [7:0]          r_scan;
   logic [7:0]          r_remaining;
   logic                r_ack;

   logic [7:0]          w_c_idx;
   logic                w_c_valid;
   logic [7:0]          w_q_idx;
   logic                w_q_valid;
   logic                w_take;

   tile_index u_collect_idx (
      .X     (Collect_X),
      .Y     (Collect_Y),
      .idx   (w_c_idx),
      .valid (w_c_valid)
   );

   tile_index u_query_idx (
      .X     (Query_X),
      .Y     (Query_Y),
      .idx   (w_q_idx),
      .valid (w_q_valid)
   );

   // A claim only lands in READY on a live, in-range tile; Load discards it.
   assign w_take = (r_state == READY) && Collect_Valid && !Load
                   && w_c_valid && r_live[w_c_idx];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      if (Load) begin
         w_next_state = COUNT;
      end else begin
         case (r_state)
            IDLE:    w_next_state = IDLE;
            COUNT:   w_next_state = (r_scan == LAST_IDX) ? READY : COUNT;
            READY:   w_next_state = READY;
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      Busy        = (r_state == COUNT);
      Level_Clear = (r_state == READY) && (r_remaining == 8'd0);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_live      <= '0;
         r_scan      <= '0;
         r_remaining <= '0;
         r_ack       <= 1'b0;
      end else if (Load) begin
         r_live      <= Map_In;
         r_scan      <= '0;
         r_remaining <= '0;
         r_ack       <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (r_state == COUNT) begin
            r_remaining <= r_remaining + {7'd0, r_live[r_scan]};
            r_scan      <= r_scan + 8'd1;
         end else if (w_take) begin
            r_live[w_c_idx] <= 1'b0;
            r_remaining     <= r_remaining - 8'd1;
            r_ack           <= 1'b1;
         end
      end
   end

   // A live bit implies a nonzero count, so a take at zero means corrupted state.
   assert property (@(posedge Clk) disable iff (Reset) w_take |-> (r_remaining != 8'd0));

   assign Treasure_Live = r_live;
   assign Remaining     = r_remaining;
   assign Collect_Ack   = r_ack;
   assign Query_Hit     = w_q_valid && r_live[w_q_idx];

endmodule

// File: tb/tb_treasure_tracker.sv
// Directed bench for treasure_tracker with a grid-level reference model checked every cycle.
module tb_treasure_tracker;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic [143:0] map_in = '0;
   logic         collect_valid = 1'b0;
   logic [3:0]   collect_x = '0;
   logic [3:0]   collect_y = '0;
   logic [3:0]   query_x = '0;
   logic [3:0]   query_y = '0;
   logic         query_hit;
   logic [143:0] treasure_live;
   logic [7:0]   remaining;
   logic         busy;
   logic         collect_ack;
   logic         level_clear;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   treasure_tracker dut (
      .Clk           (clk),
      .Reset         (reset),
      .Load          (load),
      .Map_In        (map_in),
      .Collect_Valid (collect_valid),
      .Collect_X     (collect_x),
      .Collect_Y     (collect_y),
      .Query_X       (query_x),
      .Query_Y       (query_y),
      .Query_Hit     (query_hit),
      .Treasure_Live (treasure_live),
      .Remaining     (remaining),
      .Busy          (busy),
      .Collect_Ack   (collect_ack),
      .Level_Clear   (level_clear)
   );

   always #5 clk = ~clk;

   // Reference model: a 12x12 grid of treasures plus the level phase.
   localparam int M_IDLE  = 0;
   localparam int M_COUNT = 1;
   localparam int M_READY = 2;

   bit           m_grid [12][12];
   logic [143:0] m_loaded;
   int           m_mode = M_IDLE;
   int           m_cycles = 0;
   bit           m_ack = 1'b0;

   function automatic logic [143:0] grid_vec();
      logic [143:0] v = '0;
      for (int y = 0; y < 12; y++)
         for (int x = 0; x < 12; x++)
            v[143 - (12 * y + x)] = m_grid[y][x];
      return v;
   endfunction

   function automatic int count_below(input logic [143:0] v, input int lim);
      int n = 0;
      for (int i = 0; i < lim; i++) n += int'(v[i]);
      return n;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int y = 0; y < 12; y++)
            for (int x = 0; x < 12; x++) m_grid[y][x] = 1'b0;
         m_mode = M_IDLE; m_cycles = 0; m_ack = 1'b0;
      end else if (load) begin
         for (int y = 0; y < 12; y++)
            for (int x = 0; x < 12; x++) m_grid[y][x] = map_in[143 - (12 * y + x)];
         m_loaded = map_in; m_mode = M_COUNT; m_cycles = 0; m_ack = 1'b0;
      end else begin
         m_ack = 1'b0;
         if (m_mode == M_COUNT) begin
            m_cycles++;
            if (m_cycles == 144) m_mode = M_READY;
         end else if (m_mode == M_READY && collect_valid && collect_x < 12 && collect_y < 12) begin
            if (m_grid[collect_y][collect_x]) begin
               m_grid[collect_y][collect_x] = 1'b0;
               m_ack = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int exp_rem;
         bit exp_hit;
         exp_rem = (m_mode == M_COUNT) ? count_below(m_loaded, m_cycles)
                                       : count_below(grid_vec(), 144);
         exp_hit = (query_x < 12 && query_y < 12) ? m_grid[query_y][query_x] : 1'b0;
         check("cyc_live",  treasure_live, grid_vec());
         check("cyc_rem",   144'(remaining), 144'(exp_rem));
         check("cyc_busy",  144'(busy), 144'(m_mode == M_COUNT));
         check("cyc_ack",   144'(collect_ack), 144'(m_ack));
         check("cyc_clear", 144'(level_clear), 144'(m_mode == M_READY && exp_rem == 0));
         check("cyc_hit",   144'(query_hit), 144'(exp_hit));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic collect(input logic [3:0] x, input logic [3:0] y);
      collect_valid = 1'b1; collect_x = x; collect_y = y;
      step();
      collect_valid = 1'b0;
   endtask

   task automatic set_query(input logic [3:0] x, input logic [3:0] y);
      query_x = x; query_y = y;
      #1;
   endtask

   logic [143:0] def_map;
   logic [143:0] ones_map;

   initial begin
      def_map = '0;
      def_map[104] = 1'b1;  // (3,3)
      def_map[99]  = 1'b1;  // (8,3)
      def_map[44]  = 1'b1;  // (3,8)
      def_map[39]  = 1'b1;  // (8,8)
      ones_map = '1;

      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk_en = 1'b1;
      check("rst_live",  treasure_live, '0);
      check("rst_rem",   144'(remaining), 144'd0);
      check("rst_busy",  144'(busy), 144'd0);
      check("rst_clear", 144'(level_clear), 144'd0);

      // Default level, with a claim on (8,8) mid-count that must be ignored.
      map_in = def_map; load = 1'b1;
      step();
      load = 1'b0;
      check("load_busy", 144'(busy), 144'd1);
      repeat (49) step();
      collect(4'd8, 4'd8);
      check("count_claim_ack", 144'(collect_ack), 144'd0);
      repeat (93) step();
      check("busy_e143", 144'(busy), 144'd1);
      step();
      check("busy_e144", 144'(busy), 144'd0);
      check("rem_def",   144'(remaining), 144'd4);
      check("clear_def", 144'(level_clear), 144'd0);
      set_query(4'd8, 4'd8);
      check("hit_88_kept", 144'(query_hit), 144'd1);

      // Claim (3,3); the query must not see the claim until after the edge.
      set_query(4'd3, 4'd3);
      collect_valid = 1'b1; collect_x = 4'd3; collect_y = 4'd3;
      #1;
      check("hit_33_same_cycle", 144'(query_hit), 144'd1);
      step();
      collect_valid = 1'b0;
      check("ack_33",    144'(collect_ack), 144'd1);
      check("rem_33",    144'(remaining), 144'd3);
      check("hit_33_gone", 144'(query_hit), 144'd0);
      step();
      check("ack_pulse_end", 144'(collect_ack), 144'd0);
      collect(4'd3, 4'd3);
      check("ack_33_again", 144'(collect_ack), 144'd0);
      check("rem_33_again", 144'(remaining), 144'd3);

      collect(4'd8, 4'd3);
      collect(4'd3, 4'd8);
      collect(4'd8, 4'd8);
      check("rem_all", 144'(remaining), 144'd0);
      check("clear_all", 144'(level_clear), 144'd1);
      collect(4'd15, 4'd2);
      check("ack_invalid", 144'(collect_ack), 144'd0);
      check("rem_invalid", 144'(remaining), 144'd0);

      // Load and claim together: the claim is dropped.
      map_in = def_map; load = 1'b1;
      collect_valid = 1'b1; collect_x = 4'd3; collect_y = 4'd3;
      step();
      load = 1'b0; collect_valid = 1'b0;
      check("load_claim_ack", 144'(collect_ack), 144'd0);
      repeat (144) step();
      check("load_claim_rem", 144'(remaining), 144'd4);

      // Reset mid-scan, then a full map.
      map_in = ones_map; load = 1'b1;
      step();
      load = 1'b0;
      repeat (70) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy", 144'(busy), 144'd0);
      check("midrst_rem",  144'(remaining), 144'd0);
      check("midrst_live", treasure_live, '0);
      map_in = ones_map; load = 1'b1;
      step();
      load = 1'b0;
      repeat (144) step();
      check("rem_ones", 144'(remaining), 144'd144);
      set_query(4'd11, 4'd11);
      check("hit_corner", 144'(query_hit), 144'd1);
      set_query(4'd12, 4'd0);
      check("hit_x12", 144'(query_hit), 144'd0);
      set_query(4'd0, 4'd12);
      check("hit_y12", 144'(query_hit), 144'd0);
      collect(4'd0, 4'd0);
      check("rem_ones_take", 144'(remaining), 144'd143);
      check("live_bit143", 144'(treasure_live[143]), 144'd0);
      step();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/treasure_tracker.md
TREASURE_TRACKER -- requirements
Module: treasure_tracker

Interface
REQ-001 SHALL have no parameters; grid dimensions come from the shared package (MAP_W=12, MAP_H=12, MAP_BITS=144).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Load  input  1  single-cycle pulse: capture Map_In and start a new level.
REQ-005 Map_In  input  144  treasure map from the level ROM; bits [143:132] are row 0; within a row, MSB is X=0.
REQ-006 Collect_Valid  input  1  a player claims the tile (Collect_X, Collect_Y) this cycle.
REQ-007 Collect_X, Collect_Y  input  4 each  tile coordinates of the claim.
REQ-008 Query_X, Query_Y  input  4 each  tile coordinates for the renderer lookup.
REQ-009 Query_Hit  output  1  combinational: a live treasure exists at the queried tile.
REQ-010 Treasure_Live  output  144  current live map, in the same layout as Map_In.
REQ-011 Remaining  output  8  count of live treasures, 0..144.
REQ-012 Busy  output  1  high while the tracker is counting after a Load.
REQ-013 Collect_Ack  output  1  registered one-cycle pulse: the previous cycle's claim removed a treasure.
REQ-014 Level_Clear  output  1  high in READY state when Remaining==0.

Function
REQ-015 Tile (X,Y) SHALL map to bit index 143-(12*Y+X); the tile is valid only if X<12 and Y<12.
REQ-016 FSM states SHALL be IDLE, COUNT and READY.
REQ-017 Load sampled high in any state SHALL, at that edge:
- latch Map_In into Treasure_Live;
- clear Remaining and the scan index;
- enter COUNT.
REQ-018 COUNT SHALL examine one bit per clock, index 0 first and 143 last, adding the bit to Remaining.
REQ-019 COUNT SHALL take exactly 144 edges; at the edge examining index 143, the FSM SHALL enter READY.
REQ-020 Timing from a Load at edge E0: Busy high from E0 to E144; Remaining final and Busy low after E144.
REQ-021 Collect_Valid SHALL be ignored in IDLE and COUNT.
REQ-022 In READY, a claim on a valid tile whose bit is 1 SHALL, at the same edge:
- clear that bit;
- decrement Remaining;
- set Collect_Ack for exactly the next cycle.
REQ-023 In READY, a claim on a tile whose bit is 0, or on an invalid tile, SHALL change nothing and leave Collect_Ack low.
REQ-024 Remaining SHALL never underflow; a decrement at 0 is impossible by construction and SHALL be an assertion failure.
REQ-025 Load and Collect_Valid in the same cycle: Load SHALL win and the claim SHALL be discarded (no ack).
REQ-026 Query_Hit SHALL reflect Treasure_Live in every state, including COUNT, and SHALL be 0 for an invalid tile.
REQ-027 Query_Hit SHALL NOT see a same-cycle collect; it updates after the edge.
REQ-028 Level_Clear SHALL be combinational from state and Remaining; a map loaded with all zeros SHALL give Level_Clear high on entry to READY.

Reset
REQ-029 When Reset is sampled high, the block SHALL enter IDLE and set:
- Treasure_Live=0, Remaining=0, scan index=0;
- Busy=0, Collect_Ack=0, Level_Clear=0.
REQ-030 Reset SHALL take priority over Load and Collect_Valid; Reset during COUNT SHALL abandon the scan.

Structure
REQ-031 The shared package SHALL hold MAP_W, MAP_H, MAP_BITS and the state enum (IDLE, COUNT, READY).
REQ-032 Tile-to-index conversion SHALL be a sub-module, tile_index (inputs X, Y; outputs idx[7:0], valid).
REQ-033 tile_index SHALL be instantiated twice: once for collect, once for query.

Verification
REQ-034 Default map loaded (treasures at (3,3), (8,3), (3,8), (8,8)): Load pulse -> Busy high for 144 cycles, then Remaining=4, Level_Clear=0.
REQ-035 READY, collect (3,3) -> Collect_Ack pulse next cycle, Remaining=3, Query_Hit at (3,3)=0; collect (3,3) again -> no ack, Remaining=3.
REQ-036 Collect all four treasures -> Remaining=0, Level_Clear=1; collect (15,2) -> ignored.
REQ-037 Collect_Valid at (8,8) during COUNT -> no ack, bit stays set, final Remaining=4.
REQ-038 Reset at scan index 70 -> IDLE, all outputs 0; Load with all-ones map -> Remaining=144 after 144 cycles.
REQ-039 Load and Collect_Valid at (3,3) in the same cycle -> no ack; after COUNT, Remaining=4.
